// File: rtl/button_event_decoder_pkg.sv
// Shared types and timing helpers for the button front-end blocks (debouncer, event decoder).
package button_pkg;

    typedef enum logic [1:0] {IDLE, PRESSED, LONG_HELD} btn_state_t;

    function automatic int unsigned ms_to_cycles(input int unsigned ms, input int unsigned clk_mhz);
        return ms * clk_mhz * 1000;
    endfunction

    // Counter width able to hold both terminal values; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return ($clog2(m) < 1) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/button_event_decoder_if.sv
// Level in, single-cycle events out, between the debouncer and the UI control FSM.
interface button_event_decoder_if;
    logic value_in;
    logic press;
    logic release_pulse;
    logic short_click;
    logic long_press;
    logic repeat_pulse;
    logic held;

    modport master (
        input  value_in,
        output press, release_pulse, short_click, long_press, repeat_pulse, held
    );

    modport slave (
        output value_in,
        input  press, release_pulse, short_click, long_press, repeat_pulse, held
    );
endinterface

// File: rtl/button_event_decoder_edge_detector.sv
// Registers a synchronous level once and reports its rising and falling edges.
module edge_detector #(
    parameter logic RESET_LEVEL = 1'b0
) (
    input  logic clk,
    input  logic rstN,
    input  logic level,
    output logic rise,
    output logic fall
);

    logic value_q;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            value_q <= RESET_LEVEL;
        end else begin
            value_q <= level;
        end
    end

    assign rise = level  & ~value_q;
    assign fall = ~level &  value_q;

endmodule

// File: rtl/button_event_decoder.sv
// Turns a debounced button level into press/release/click/long-press/auto-repeat events.
//
//   state     | meaning
//   ----------+--------------------------------------------------------------
//   IDLE      | button up, waiting for a press edge
//   PRESSED   | held for less than the long-press time; release gives a click
//   LONG_HELD | long press already reported; counting auto-repeat periods
module button_event_decoder
    import button_pkg::*;
#(
    parameter int unsigned CLK_FREQ      = 50,
    parameter int unsigned LONG_PRESS_MS = 500,
    parameter int unsigned REPEAT_MS     = 100,
    parameter logic        ACTIVE_LEVEL  = 1'b1
) (
    input logic               clk,
    input logic               rstN,
    button_event_decoder_if.master bus
);

    localparam int unsigned LONG_CYCLES   = ms_to_cycles(LONG_PRESS_MS, CLK_FREQ);
    localparam int unsigned REPEAT_CYCLES = ms_to_cycles(REPEAT_MS, CLK_FREQ);
    localparam int unsigned CNT_W         = cnt_width(LONG_CYCLES, REPEAT_CYCLES);
    localparam logic [CNT_W-1:0] LONG_TC   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_TC = CNT_W'(REPEAT_CYCLES - 1);

    btn_state_t       state;
    logic [CNT_W-1:0] count;
    logic             active;
    logic             rise;
    logic             fall;
    logic             press_q, release_q, short_q, long_q, repeat_q, held_q;

    // Normalise polarity so the edge detector always sees "1 = pressed".
    assign active = (bus.value_in == ACTIVE_LEVEL);

    edge_detector #(
        .RESET_LEVEL(1'b0)
    ) u_edge (
        .clk  (clk),
        .rstN (rstN),
        .level(active),
        .rise (rise),
        .fall (fall)
    );

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state     <= IDLE;
            count     <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            short_q   <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
            held_q    <= 1'b0;
        end else begin
            press_q   <= 1'b0;
            release_q <= 1'b0;
            short_q   <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (rise) begin
                        press_q <= 1'b1;
                        held_q  <= 1'b1;
                        count   <= '0;
                        state   <= PRESSED;
                    end
                end
                PRESSED: begin
                    // Release takes priority over reaching the terminal count.
                    if (fall) begin
                        release_q <= 1'b1;
                        short_q   <= 1'b1;
                        held_q    <= 1'b0;
                        count     <= '0;
                        state     <= IDLE;
                    end else if (count == LONG_TC) begin
                        long_q <= 1'b1;
                        count  <= '0;
                        state  <= LONG_HELD;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                LONG_HELD: begin
                    if (fall) begin
                        release_q <= 1'b1;
                        held_q    <= 1'b0;
                        count     <= '0;
                        state     <= IDLE;
                    end else if (count == REPEAT_TC) begin
                        repeat_q <= 1'b1;
                        count    <= '0;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    count  <= '0;
                    held_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.press         = press_q;
    assign bus.release_pulse = release_q;
    assign bus.short_click   = short_q;
    assign bus.long_press    = long_q;
    assign bus.repeat_pulse  = repeat_q;
    assign bus.held          = held_q;

endmodule

// File: tb/tb_button_event_decoder.sv
// Directed bench for button_event_decoder with 1000-cycle long-press and repeat periods.
module tb_button_event_decoder;

    logic clk  = 1'b0;
    logic rstN = 1'b0;

    always #5 clk = ~clk;

    button_event_decoder_if bif ();

    button_event_decoder #(
        .CLK_FREQ     (1),
        .LONG_PRESS_MS(1),
        .REPEAT_MS    (1),
        .ACTIVE_LEVEL (1'b1)
    ) dut (
        .clk (clk),
        .rstN(rstN),
        .bus (bif)
    );

    int checks = 0;
    int errors = 0;
    int cyc, n_press, n_rel, n_short, n_long, n_rep, n_held, n_excl;
    int long_at, rep_first, rep_last;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] outs();
        return {bif.press, bif.release_pulse, bif.short_click,
                bif.long_press, bif.repeat_pulse, bif.held};
    endfunction

    task automatic clr();
        cyc = 0; n_press = 0; n_rel = 0; n_short = 0; n_long = 0;
        n_rep = 0; n_held = 0; long_at = -1; rep_first = -1; rep_last = -1;
    endtask

    task automatic step();
        int pulses;
        @(posedge clk);
        #1;
        cyc++;
        if (bif.press)         n_press++;
        if (bif.release_pulse) n_rel++;
        if (bif.short_click)   n_short++;
        if (bif.held)          n_held++;
        if (bif.long_press) begin
            n_long++;
            if (long_at < 0) long_at = cyc;
        end
        if (bif.repeat_pulse) begin
            n_rep++;
            if (rep_first < 0) rep_first = cyc;
            rep_last = cyc;
        end
        pulses = int'(bif.press) + int'(bif.release_pulse) + int'(bif.long_press) + int'(bif.repeat_pulse);
        if (pulses > 1 || (bif.short_click && !bif.release_pulse)) n_excl++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        n_excl = 0;
        clr();
        bif.value_in = 1'b1;

        // Button held through reset
        run(3);
        chk("reset_outs", 32'(outs()), 0);
        rstN = 1'b1;
        clr();
        step();
        chk("post_reset_press", 32'(bif.press), 1);
        chk("post_reset_held", 32'(bif.held), 1);
        bif.value_in = 1'b0;
        step();
        chk("post_reset_release", 32'(bif.release_pulse), 1);
        chk("post_reset_short", 32'(bif.short_click), 1);
        chk("post_reset_held_off", 32'(bif.held), 0);
        run(3);

        // Short click: 10 cycles held
        clr();
        bif.value_in = 1'b1;
        run(10);
        bif.value_in = 1'b0;
        step();
        chk("short_n_press", 32'(n_press), 1);
        chk("short_held_cycles", 32'(n_held), 10);
        chk("short_release", 32'(bif.release_pulse), 1);
        chk("short_click", 32'(bif.short_click), 1);
        chk("short_n_release", 32'(n_rel), 1);
        chk("short_no_long", 32'(n_long), 0);
        run(3);

        // Long hold: 3500 cycles
        clr();
        bif.value_in = 1'b1;
        run(3500);
        bif.value_in = 1'b0;
        step();
        chk("long_count", 32'(n_long), 1);
        chk("long_at", 32'(long_at), 1001);
        chk("repeat_count", 32'(n_rep), 2);
        chk("repeat_first", 32'(rep_first), 2001);
        chk("repeat_last", 32'(rep_last), 3001);
        chk("long_release", 32'(bif.release_pulse), 1);
        chk("long_no_short", 32'(n_short), 0);
        chk("long_held_cycles", 32'(n_held), 3500);
        run(3);

        // Release exactly when the counter is at its terminal value
        clr();
        bif.value_in = 1'b1;
        run(1000);
        bif.value_in = 1'b0;
        step();
        chk("bound_release", 32'(bif.release_pulse), 1);
        chk("bound_short", 32'(bif.short_click), 1);
        chk("bound_no_long", 32'(n_long), 0);
        run(3);

        // One cycle later: long press fires, then a plain release
        clr();
        bif.value_in = 1'b1;
        run(1001);
        bif.value_in = 1'b0;
        step();
        chk("bound1_long_at", 32'(long_at), 1001);
        chk("bound1_release", 32'(bif.release_pulse), 1);
        chk("bound1_no_short", 32'(bif.short_click), 0);
        run(3);

        // Back-to-back release and press
        clr();
        bif.value_in = 1'b1;
        run(5);
        bif.value_in = 1'b0;
        step();
        chk("b2b_release", 32'(bif.release_pulse), 1);
        chk("b2b_release_no_press", 32'(bif.press), 0);
        bif.value_in = 1'b1;
        step();
        chk("b2b_press", 32'(bif.press), 1);
        chk("b2b_press_no_release", 32'(bif.release_pulse), 0);
        chk("b2b_held", 32'(bif.held), 1);
        bif.value_in = 1'b0;
        step();
        chk("b2b_second_release", 32'(bif.release_pulse), 1);
        run(2);

        // Reset in the middle of a long hold
        clr();
        bif.value_in = 1'b1;
        run(1500);
        chk("midhold_long_at", 32'(long_at), 1001);
        chk("midhold_held", 32'(bif.held), 1);
        rstN = 1'b0;
        #1;
        chk("midhold_async_clear", 32'(outs()), 0);
        bif.value_in = 1'b0;
        clr();
        run(3);
        chk("midhold_in_reset", 32'(outs()), 0);
        rstN = 1'b1;
        run(3);
        chk("midhold_no_release", 32'(n_rel), 0);
        chk("midhold_no_press", 32'(n_press), 0);
        bif.value_in = 1'b1;
        step();
        chk("after_reset_press", 32'(bif.press), 1);
        chk("after_reset_held", 32'(bif.held), 1);
        bif.value_in = 1'b0;
        step();
        chk("after_reset_short", 32'(bif.short_click), 1);
        run(2);

        chk("exclusivity", 32'(n_excl), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/button_event_decoder.md
Name: button_event_decoder

Overview:
- Sits directly downstream of the debouncer and consumes its clean, bounce-free `value_out` level.
- Converts that level into single-cycle user events: press, release, short click, long press, and auto-repeat while held.
- Feeds the user-interface / control FSM that drives the serial-bus master (start, select, step).
- Operates entirely in the 50 MHz system clock domain.

Parameters:
- CLK_FREQ, 50, clock frequency in MHz.
- LONG_PRESS_MS, 500, hold time in ms before `long_press` fires; LONG_CYCLES = LONG_PRESS_MS*CLK_FREQ*1000.
- REPEAT_MS, 100, auto-repeat period in ms after the long press; REPEAT_CYCLES = REPEAT_MS*CLK_FREQ*1000.
- ACTIVE_LEVEL, 1'b1, level of `value_in` that means "button pressed".

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rstN  input  1  asynchronous active-low reset.
- value_in  input  1  debounced button level from the debouncer; already synchronous to clk.
- press  output  1  one-cycle pulse on press.
- release  output  1  one-cycle pulse on release.
- short_click  output  1  one-cycle pulse on release before the long-press time (same cycle as `release`).
- long_press  output  1  one-cycle pulse when the hold reaches LONG_CYCLES.
- repeat  output  1  one-cycle pulse every REPEAT_CYCLES after `long_press` while still held.
- held  output  1  level; high from the `press` cycle until the `release` cycle, inclusive of `press`, exclusive of `release`.

Behaviour:
- Reset state, applied asynchronously on rstN low:
  - state = IDLE, counter = 0.
  - value_q = inactive level (~ACTIVE_LEVEL).
  - All outputs 0.
  - Consequence: a button held through reset produces `press` on the first edge after rstN deasserts.
- Registration and latency:
  - `value_in` is registered once into value_q; a press is detected when value_in == ACTIVE_LEVEL and value_q != ACTIVE_LEVEL.
  - All outputs are registered.
  - Latency: if value_in first goes active before clock edge k, `press` is high from edge k to k+1 (one cycle).
- State IDLE:
  - On press detection: pulse `press`, set `held`, clear counter, go PRESSED.
  - Otherwise stay IDLE.
- State PRESSED:
  - Counter increments each cycle.
  - If value_in goes inactive: pulse `release` and `short_click` together, clear `held`, go IDLE.
  - Else if counter == LONG_CYCLES-1: pulse `long_press`, clear counter, go LONG_HELD.
  - Result: `long_press` is exactly LONG_CYCLES cycles after `press`.
- State LONG_HELD:
  - Counter increments each cycle.
  - If value_in goes inactive: pulse `release` only (no `short_click`), clear `held`, go IDLE.
  - Else if counter == REPEAT_CYCLES-1: pulse `repeat`, clear counter.
  - Result: the first `repeat` is REPEAT_CYCLES after `long_press`, then periodic.
- Boundary and priority rules:
  - Release on the same cycle the counter hits its terminal value: release wins; no `long_press` / `repeat`.
  - A new press in the cycle right after a release is detected normally; IDLE needs no dwell.
- Counter width: $clog2(max(LONG_CYCLES, REPEAT_CYCLES)); it never wraps, because it is cleared at each terminal value.
- Output exclusivity:
  - At most one of press / release / long_press / repeat is high in any cycle.
  - `short_click` only ever coincides with `release`.
- Reset mid-hold: immediately IDLE with all outputs 0; no `release` pulse is generated.
- Inputs are not re-synchronised; upstream guarantees a glitch-free synchronous level.

Decomposition:
- Shared package `button_pkg` contains:
  - typedef enum logic [1:0] {IDLE, PRESSED, LONG_HELD} btn_state_t;
  - function ms_to_cycles(ms, clk_mhz), reused by the debouncer and this block.
- One natural sub-module, `edge_detector` (clk, rstN, level, rise, fall; reset level parameterised), which provides value_q and the press/release edge terms.
- Counter and FSM stay in the top module.

Test Plan (bench overrides CLK_FREQ=1, LONG_PRESS_MS=1, REPEAT_MS=1, ACTIVE_LEVEL=1, so LONG_CYCLES = REPEAT_CYCLES = 1000):
- Reset: hold rstN=0 with value_in=1, release reset → all outputs 0 during reset; `press` pulses on the first edge after reset; `held`=1.
- Short click: value_in high for 10 cycles then low → `press` 1 cycle; `held` high 10 cycles; `release` and `short_click` high on the same single cycle; no `long_press`.
- Long hold: value_in high 3500 cycles → `long_press` at cycle 1000 after `press`; `repeat` at cycles 2000 and 3000; `release` without `short_click`.
- Boundary: release timed so value_in drops exactly on counter == 999 → `release` + `short_click`; no `long_press`.
- Back-to-back: release then press on the very next cycle → `release` and `press` in consecutive cycles, never the same cycle.
- Reset mid-hold: assert rstN low 1500 cycles into a hold → outputs 0 immediately; no `release`; FSM in IDLE; new press after reset works.
